// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared state type, widths and constants for the instruction fetch unit
package ifu_pkg;
  localparam int                 INSTR_W   = 32;
  localparam logic [31:0]        PC_STEP   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [2:0] {IDLE, REQ, HOLD, DROP, FAULT} ifu_state_e;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction
endpackage

// File: rtl/ifu_if.sv
// rtl/ifu_if.sv - instruction memory request/ack bus between fetch unit and memory
interface ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifu_skid_buf.sv
// rtl/ifu_skid_buf.sv - one-entry skid buffer holding a fetched word and its address
module ifu_skid_buf
  import ifu_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_data,
  input  logic [31:0]        i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_data,
  output logic [31:0]        o_pc
);
  logic               r_valid;
  logic [INSTR_W-1:0] r_data;
  logic [31:0]        r_pc;

  // clear wins over load so a redirect can never leak a captured word
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_data  <= NOP_INSTR;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_pc    = r_pc;
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM with stall skid and redirect drop; IFU_ALIGN_CHECK_EN adds misaligned-target fault
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  ifu_if.master              imem,
  output logic [INSTR_W-1:0] instruction,
  output logic [31:0]        outPC,
  output logic               if_valid,
  output logic               fetch_fault
);
  ifu_state_e         r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_stale_addr;
  logic [31:0]        r_out_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic               r_fault;

  logic [31:0]        w_target;
  logic               w_misaligned;
  logic               w_busy;
  logic               w_ack;
  logic               w_skid_load;
  logic               w_skid_clear;
  logic               w_skid_valid;
  logic [INSTR_W-1:0] w_skid_data;
  logic [31:0]        w_skid_pc;

`ifdef IFU_ALIGN_CHECK_EN
  assign w_target     = redirect_pc;
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^redirect_pc[1:0];
  assign w_target     = {redirect_pc[31:2], 2'b00};
  assign w_misaligned = 1'b0;
`endif

  // DROP keeps presenting the stale address until its ack retires it
  assign w_busy         = (r_state == REQ) || (r_state == DROP);
  assign w_ack          = w_busy && imem.imem_ack;
  assign imem.imem_req  = w_busy;
  assign imem.imem_addr = (r_state == DROP) ? r_stale_addr : r_pc;

  assign w_skid_load  = (r_state == REQ) && w_ack && stall && !redirect_valid;
  assign w_skid_clear = redirect_valid || ((r_state == HOLD) && !stall);

  ifu_skid_buf u_skid (
    .clk     (clk),
    .resetn  (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (imem.imem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_pc    (w_skid_pc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_stale_addr <= '0;
      r_out_pc     <= '0;
      r_instr      <= NOP_INSTR;
      r_valid      <= 1'b0;
      r_fault      <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= w_target;
      if (w_misaligned) begin
        r_state  <= FAULT;
        r_fault  <= 1'b1;
        r_valid  <= 1'b1;
        r_out_pc <= w_target;
        r_instr  <= NOP_INSTR;
      end else begin
        r_fault <= 1'b0;
        r_valid <= 1'b0;
        r_state <= (w_busy && !w_ack) ? DROP : REQ;
        if (r_state == REQ) r_stale_addr <= r_pc;
      end
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (stall) begin
            if (w_ack) r_state <= HOLD;
          end else if (w_ack) begin
            r_instr  <= imem.imem_rdata;
            r_out_pc <= r_pc;
            r_valid  <= 1'b1;
            r_pc     <= next_pc(r_pc);
          end else begin
            r_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall && w_skid_valid) begin
            r_instr  <= w_skid_data;
            r_out_pc <= w_skid_pc;
            r_valid  <= 1'b1;
            r_pc     <= next_pc(r_pc);
            r_state  <= REQ;
          end
        end
        DROP: if (w_ack) r_state <= REQ;
        default: r_state <= r_state;
      endcase
    end
  end

  assign instruction = r_instr;
  assign outPC       = r_out_pc;
  assign if_valid    = r_valid;
  assign fetch_fault = r_fault;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector table, corner sequences and randomized reference-model check
module tb_instr_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] outPC;
  logic        if_valid;
  logic        fetch_fault;

  ifu_if bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .instruction    (instruction),
    .outPC          (outPC),
    .if_valid       (if_valid),
    .fetch_fault    (fetch_fault)
  );

  // memory returns a word derived from the address it was asked for
  assign bus.imem_rdata = bus.imem_addr ^ K;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic r, input logic [31:0] t);
    stall          = s;
    bus.imem_ack   = a;
    redirect_valid = r;
    redirect_pc    = t;
    @(negedge clk);
  endtask

  typedef struct {
    logic        stall;
    logic        ack;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[33];

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } skid_t;

  logic        m_started;
  logic        m_pending;
  logic        m_stale;
  logic [31:0] m_req_addr;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_outpc;
  logic [31:0] m_instr;
  skid_t       skid_q[$];

  // transaction-level view: one in-flight request, a possibly-stale flag, a parked word queue
  task automatic model_step(input logic s, input logic a, input logic r, input logic [31:0] t);
    logic  ack;
    skid_t e;
    ack = a && m_pending;
    if (r) begin
      m_valid = 1'b0;
      skid_q.delete();
      m_pc = t;
      if (m_pending && !ack) m_stale = 1'b1;
      else begin
        m_pending  = 1'b1;
        m_req_addr = t;
        m_stale    = 1'b0;
      end
      m_started = 1'b1;
    end else if (!m_started) begin
      m_started  = 1'b1;
      m_pending  = 1'b1;
      m_req_addr = m_pc;
    end else if (skid_q.size() != 0) begin
      if (!s) begin
        e          = skid_q.pop_front();
        m_valid    = 1'b1;
        m_outpc    = e.pc;
        m_instr    = e.data;
        m_pc       = e.pc + 32'd4;
        m_pending  = 1'b1;
        m_req_addr = m_pc;
      end
    end else if (ack) begin
      if (m_stale) begin
        m_stale    = 1'b0;
        m_req_addr = m_pc;
      end else if (s) begin
        skid_q.push_back('{m_req_addr ^ K, m_req_addr});
        m_pending = 1'b0;
      end else begin
        m_valid    = 1'b1;
        m_outpc    = m_req_addr;
        m_instr    = m_req_addr ^ K;
        m_pc       = m_req_addr + 32'd4;
        m_req_addr = m_pc;
      end
    end else if (!s) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    logic        s;
    logic        a;
    logic        r;
    logic [31:0] t;

    vecs[0]  = '{0, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0};
    vecs[1]  = '{0, 1, 0, 32'h0,         1, 32'h4,         1, 32'h0};
    vecs[2]  = '{0, 1, 0, 32'h0,         1, 32'h8,         1, 32'h4};
    vecs[3]  = '{0, 1, 0, 32'h0,         1, 32'hC,         1, 32'h8};
    vecs[4]  = '{0, 1, 0, 32'h0,         1, 32'h10,        1, 32'hC};
    vecs[5]  = '{1, 1, 0, 32'h0,         0, 32'h0,         1, 32'hC};
    vecs[6]  = '{1, 0, 0, 32'h0,         0, 32'h0,         1, 32'hC};
    vecs[7]  = '{1, 0, 0, 32'h0,         0, 32'h0,         1, 32'hC};
    vecs[8]  = '{0, 0, 0, 32'h0,         1, 32'h14,        1, 32'h10};
    vecs[9]  = '{0, 1, 0, 32'h0,         1, 32'h18,        1, 32'h14};
    vecs[10] = '{0, 0, 0, 32'h0,         1, 32'h18,        0, 32'h0};
    vecs[11] = '{0, 1, 0, 32'h0,         1, 32'h1C,        1, 32'h18};
    vecs[12] = '{0, 1, 0, 32'h0,         1, 32'h20,        1, 32'h1C};
    vecs[13] = '{0, 0, 1, 32'h100,       1, 32'h20,        0, 32'h0};
    vecs[14] = '{0, 0, 0, 32'h0,         1, 32'h20,        0, 32'h0};
    vecs[15] = '{0, 1, 0, 32'h0,         1, 32'h100,       0, 32'h0};
    vecs[16] = '{0, 1, 0, 32'h0,         1, 32'h104,       1, 32'h100};
    vecs[17] = '{0, 1, 1, 32'h28,        1, 32'h28,        0, 32'h0};
    vecs[18] = '{0, 1, 0, 32'h0,         1, 32'h2C,        1, 32'h28};
    vecs[19] = '{0, 1, 0, 32'h0,         1, 32'h30,        1, 32'h2C};
    vecs[20] = '{1, 1, 1, 32'h200,       1, 32'h200,       0, 32'h0};
    vecs[21] = '{0, 1, 0, 32'h0,         1, 32'h204,       1, 32'h200};
    vecs[22] = '{0, 0, 1, 32'hFFFF_FFFC, 1, 32'h204,       0, 32'h0};
    vecs[23] = '{0, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0};
    vecs[24] = '{0, 1, 0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFFC};
    vecs[25] = '{0, 1, 0, 32'h0,         1, 32'h4,         1, 32'h0};
    vecs[26] = '{0, 0, 1, 32'h300,       1, 32'h4,         0, 32'h0};
    vecs[27] = '{0, 0, 1, 32'h400,       1, 32'h4,         0, 32'h0};
    vecs[28] = '{0, 1, 0, 32'h0,         1, 32'h400,       0, 32'h0};
    vecs[29] = '{0, 1, 0, 32'h0,         1, 32'h404,       1, 32'h400};
    vecs[30] = '{1, 1, 0, 32'h0,         0, 32'h0,         1, 32'h400};
    vecs[31] = '{1, 0, 1, 32'h500,       1, 32'h500,       0, 32'h0};
    vecs[32] = '{0, 1, 0, 32'h0,         1, 32'h504,       1, 32'h500};

    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    bus.imem_ack = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("reset if_valid", {31'd0, if_valid}, 32'd0);
    check("reset outPC", outPC, 32'd0);
    check("reset instruction", instruction, 32'd0);
    check("reset imem_req", {31'd0, bus.imem_req}, 32'd0);
    check("reset fetch_fault", {31'd0, fetch_fault}, 32'd0);

    reset = 1'b1;
    for (int i = 0; i < 33; i++) begin
      drive(vecs[i].stall, vecs[i].ack, vecs[i].redir, vecs[i].rpc);
      check($sformatf("vec%0d imem_req", i), {31'd0, bus.imem_req}, {31'd0, vecs[i].e_req});
      if (vecs[i].e_req) check($sformatf("vec%0d imem_addr", i), bus.imem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d outPC", i), outPC, vecs[i].e_pc);
        check($sformatf("vec%0d instruction", i), instruction, vecs[i].e_pc ^ K);
      end
    end

`ifdef IFU_ALIGN_CHECK_EN
    drive(0, 0, 1, 32'h102);
    check("fault set", {31'd0, fetch_fault}, 32'd1);
    check("fault if_valid", {31'd0, if_valid}, 32'd1);
    check("fault outPC", outPC, 32'h102);
    check("fault instruction", instruction, 32'h0);
    check("fault imem_req", {31'd0, bus.imem_req}, 32'd0);
    drive(0, 0, 0, 32'h0);
    check("fault sticky", {31'd0, fetch_fault}, 32'd1);
    check("fault sticky req", {31'd0, bus.imem_req}, 32'd0);
    drive(0, 0, 1, 32'h104);
    check("fault cleared", {31'd0, fetch_fault}, 32'd0);
    check("fault exit req", {31'd0, bus.imem_req}, 32'd1);
    check("fault exit addr", bus.imem_addr, 32'h104);
    drive(0, 1, 0, 32'h0);
    check("after fault outPC", outPC, 32'h104);
    check("after fault instruction", instruction, 32'h104 ^ K);
`else
    drive(0, 0, 1, 32'h102);
    check("unaligned no fault", {31'd0, fetch_fault}, 32'd0);
    check("unaligned if_valid", {31'd0, if_valid}, 32'd0);
    drive(0, 1, 0, 32'h0);
    check("unaligned addr", bus.imem_addr, 32'h100);
    drive(0, 1, 0, 32'h0);
    check("unaligned outPC", outPC, 32'h100);
    check("unaligned if_valid2", {31'd0, if_valid}, 32'd1);
    check("unaligned instruction", instruction, 32'h100 ^ K);
`endif

    // reset while a request is outstanding and the memory keeps acking
    reset = 1'b0;
    drive(0, 1, 0, 32'h0);
    drive(0, 1, 0, 32'h0);
    check("midreset if_valid", {31'd0, if_valid}, 32'd0);
    check("midreset imem_req", {31'd0, bus.imem_req}, 32'd0);
    check("midreset outPC", outPC, 32'd0);
    check("midreset instruction", instruction, 32'd0);
    reset = 1'b1;
    drive(0, 0, 0, 32'h0);
    check("restart addr", bus.imem_addr, 32'h0);
    check("restart req", {31'd0, bus.imem_req}, 32'd1);
    drive(0, 1, 0, 32'h0);
    check("restart outPC", outPC, 32'h0);
    check("restart if_valid", {31'd0, if_valid}, 32'd1);

    reset = 1'b0;
    drive(0, 0, 0, 32'h0);
    drive(0, 0, 0, 32'h0);
    m_started  = 1'b0;
    m_pending  = 1'b0;
    m_stale    = 1'b0;
    m_req_addr = 32'h0;
    m_pc       = 32'h0;
    m_valid    = 1'b0;
    m_outpc    = 32'h0;
    m_instr    = 32'h0;
    skid_q.delete();
    reset = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 2) != 0) && bus.imem_req;
      r = ($urandom_range(0, 11) == 0);
      t = $urandom;
      t[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
      model_step(s, a, r, t);
      drive(s, a, r, t);
      check($sformatf("rnd%0d imem_req", i), {31'd0, bus.imem_req}, {31'd0, m_pending});
      if (m_pending) check($sformatf("rnd%0d imem_addr", i), bus.imem_addr, m_req_addr);
      check($sformatf("rnd%0d if_valid", i), {31'd0, if_valid}, {31'd0, m_valid});
      if (m_valid) begin
        check($sformatf("rnd%0d outPC", i), outPC, m_outpc);
        check($sformatf("rnd%0d instruction", i), instruction, m_instr);
      end
      check($sformatf("rnd%0d fetch_fault", i), {31'd0, fetch_fault}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded at reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-low (0 = reset), sampled on posedge clk.
REQ-004 stall  input  1  downstream IF/ID register cannot accept; hold outputs.
REQ-005 redirect_valid  input  1  branch/jump taken; redirect fetch this cycle.
REQ-006 redirect_pc  input  32  redirect target address.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address; stable while imem_req=1 and not acked.
REQ-009 imem_ack  input  1  memory completes request; imem_rdata valid same cycle.
REQ-010 imem_rdata  input  32  fetched word.
REQ-011 instruction  output  32  fetched word to IF/ID register.
REQ-012 outPC  output  32  address of instruction.
REQ-013 if_valid  output  1  instruction/outPC valid.
REQ-014 fetch_fault  output  1  misaligned-target fault (see Configuration).

Function
REQ-015 States SHALL be IDLE, REQ, HOLD, DROP, FAULT; encoded as a package enum.
REQ-016 IDLE -> REQ the first cycle after reset deasserts; imem_req=1, imem_addr=pc.
REQ-017 REQ: imem_req=1 until imem_ack; imem_addr SHALL NOT change while waiting.
REQ-018 Ack, no stall, no redirect: instruction<=imem_rdata, outPC<=pc, if_valid<=1, pc<=pc+4 (mod 2^32, wrap silently), stay REQ; back-to-back acks give 1 instruction/cycle.
REQ-019 No ack in a cycle with no stall: if_valid<=0 (bubble).
REQ-020 stall=1: instruction, outPC, if_valid SHALL hold; a new request SHALL NOT be issued.
REQ-021 Ack while stall=1 and if_valid=1: word captured in 1-entry skid buffer, state -> HOLD, imem_req=0.
REQ-022 HOLD: on stall=0, skid word moves to outputs (if_valid=1), pc<=pc+4, state -> REQ next cycle.
REQ-023 redirect_valid has priority over stall and ack: pc<=redirect_pc, if_valid<=0, skid buffer cleared.
REQ-024 Redirect with request outstanding and no ack same cycle: state -> DROP; the next ack is discarded, then REQ at redirect_pc.
REQ-025 Redirect coincident with ack: data discarded, state -> REQ at redirect_pc next cycle.
REQ-026 Redirect in DROP: update pc to latest target, remain DROP.

Reset
REQ-027 reset=0: pc=RESET_PC, state=IDLE, instruction=0, outPC=0, if_valid=0, imem_req=0, fetch_fault=0, skid empty.
REQ-028 Reset mid-request SHALL abandon it; an ack arriving during reset SHALL be ignored.

Configuration
REQ-029 Macro IFU_ALIGN_CHECK_EN.
REQ-030 Defined: redirect_pc[1:0]!=0 -> state FAULT next cycle, fetch_fault=1, if_valid=1, outPC=redirect_pc, instruction=0, no imem_req; exit only on next aligned redirect.
REQ-031 Undefined: redirect_pc[1:0] forced to 2'b00, FAULT unreachable, fetch_fault tied 0.

Structure
REQ-032 Package ifu_pkg SHALL hold the state enum, INSTR_W=32, PC_STEP=4, NOP_INSTR=32'h0.
REQ-033 Skid buffer SHALL be sub-module ifu_skid_buf (1 entry, data+pc, valid flag, clear input).

Verification
REQ-034 Reset, RESET_PC=0, ack every cycle, rdata=addr^32'hA5A5_0000 -> outPC 0,4,8,... one per cycle, if_valid=1 from 2nd cycle after reset release.
REQ-035 stall=1 for 3 cycles with ack pending at pc=0x10 -> outputs hold pc 0x0C, HOLD entered, after release outPC=0x10 then 0x14, no word lost or duplicated.
REQ-036 redirect to 0x100 while request to 0x20 outstanding, ack 2 cycles later -> stale word dropped, next imem_addr=0x100, next valid outPC=0x100.
REQ-037 redirect to 0x200 same cycle as ack for 0x30 and stall=1 -> 0x30 discarded, if_valid=0, next imem_addr=0x200.
REQ-038 pc=0xFFFF_FFFC ack -> next imem_addr=0x0000_0000.
REQ-039 IFU_ALIGN_CHECK_EN defined, redirect to 0x102 -> fetch_fault=1, outPC=0x102, imem_req=0; redirect to 0x104 clears fault; undefined build fetches 0x100.
